// File: rtl/cam_capture_scaler_if.sv
// Camera byte bus and frame-buffer write port of cam_capture_scaler.
// slave = capture stage, master = camera pins / RAM side.
interface cam_capture_scaler_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 16
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  dout;
    logic              we;

    modport master (
        output vsync, href, d,
        input  addr, dout, we
    );

    modport slave (
        input  vsync, href, d,
        output addr, dout, we
    );
endinterface

// File: rtl/cam_capture_scaler.sv
// Camera capture: byte-to-pixel assembly, H/V decimation, frame-buffer writes.
// Define CAM_WINDOW_EN to add a pre-decimation crop window (X0, Y0, WIN_W, WIN_H).
module cam_capture_scaler #(
    parameter int BPP        = 2,
    parameter int H_DEC      = 2,
    parameter int V_DEC      = 2,
    parameter int ADDR_W     = 17,
    parameter int DEPTH      = 76800,
    parameter int CONTINUOUS = 1
`ifdef CAM_WINDOW_EN
    ,
    parameter int X0    = 0,
    parameter int Y0    = 0,
    parameter int WIN_W = 640,
    parameter int WIN_H = 480
`endif
) (
    input  logic                 pclk,
    input  logic                 reset,
    cam_capture_scaler_if.slave  bus,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow,
    output logic [ADDR_W:0]      pix_count
);
    localparam int PIX_W = 8 * BPP;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0] BCNT_LAST = 2'(BPP - 1);
    localparam logic [3:0] COL_LAST = 4'(H_DEC - 1);
    localparam logic [3:0] ROW_LAST = 4'(V_DEC - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
    state_t state, state_nx;

    logic             vs_r, hr_r, vs_q, hr_q;
    logic [7:0]       d_r;
    logic [1:0]       bcnt;
    logic [3:0]       col_ph, row_ph;
    logic [PIX_W-1:0] pix;
    logic             pix_done, pix_keep;
    logic [ADDR_W:0]  addr_next;
    logic             vs_rise, vs_fall, hr_fall, last_byte;
    logic             win_ok, col_adv, row_adv, do_write;

    assign vs_rise   = vs_r & ~vs_q;
    assign vs_fall   = vs_q & ~vs_r;
    assign hr_fall   = hr_q & ~hr_r;
    assign last_byte = hr_r && (bcnt == BCNT_LAST);
    assign busy      = (state != IDLE);

`ifdef CAM_WINDOW_EN
    logic [15:0] x, y;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else begin
            if (!hr_r)
                x <= '0;
            else if (last_byte)
                x <= x + 16'd1;
            if (vs_r)
                y <= '0;
            else if (hr_fall)
                y <= y + 16'd1;
        end
    end

    // Phases only advance inside the window so its origin is always kept
    assign col_adv = (32'(x) >= X0);
    assign row_adv = (32'(y) >= Y0);
    assign win_ok  = col_adv && (32'(x) < X0 + WIN_W)
                  && row_adv && (32'(y) < Y0 + WIN_H);
`else
    assign col_adv = 1'b1;
    assign row_adv = 1'b1;
    assign win_ok  = 1'b1;
`endif

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vs_r     <= 1'b0;
            hr_r     <= 1'b0;
            d_r      <= '0;
            vs_q     <= 1'b0;
            hr_q     <= 1'b0;
            bcnt     <= '0;
            col_ph   <= '0;
            row_ph   <= '0;
            pix      <= '0;
            pix_done <= 1'b0;
            pix_keep <= 1'b0;
        end else begin
            vs_r     <= bus.vsync;
            hr_r     <= bus.href;
            d_r      <= bus.d;
            vs_q     <= vs_r;
            hr_q     <= hr_r;
            pix_done <= last_byte;
            pix_keep <= win_ok && (col_ph == '0) && (row_ph == '0);
            if (hr_r) begin
                pix  <= PIX_W'({pix, d_r});
                bcnt <= last_byte ? 2'd0 : bcnt + 2'd1;
            end else begin
                bcnt <= '0;
            end
            if (!hr_r)
                col_ph <= '0;
            else if (last_byte && col_adv)
                col_ph <= (col_ph == COL_LAST) ? 4'd0 : col_ph + 4'd1;
            if (vs_r)
                row_ph <= '0;
            else if (hr_fall && row_adv)
                row_ph <= (row_ph == ROW_LAST) ? 4'd0 : row_ph + 4'd1;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ARMED;
            ARMED:   if (vs_fall) state_nx = CAPTURE;
            CAPTURE: if (vs_rise) state_nx = (CONTINUOUS != 0) ? ARMED : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame end wins over a pixel finishing on the same edge
    assign do_write = (state == CAPTURE) && !vs_rise && pix_done && pix_keep;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            bus.addr   <= '0;
            bus.dout   <= '0;
            bus.we     <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            pix_count  <= '0;
            addr_next  <= '0;
        end else begin
            bus.we     <= 1'b0;
            frame_done <= 1'b0;
            if (state == ARMED && vs_fall) begin
                addr_next <= '0;
                overflow  <= 1'b0;
            end else if (state == CAPTURE && vs_rise) begin
                frame_done <= 1'b1;
                pix_count  <= addr_next;
            end else if (do_write) begin
                if (addr_next < DEPTH_L) begin
                    bus.we    <= 1'b1;
                    bus.addr  <= addr_next[ADDR_W-1:0];
                    bus.dout  <= pix;
                    addr_next <= addr_next + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_scaler.sv
// Bench for cam_capture_scaler: two instances share one camera stream,
// expected writes are queued at drive time and popped on each we.
`timescale 1ns/1ps
module tb_cam_capture_scaler;
    localparam int A0 = 7;
    localparam int D0 = 100;
    localparam int B0 = 2;
    localparam int H0 = 1;
    localparam int V0 = 1;
    localparam int A1 = 17;
    localparam int D1 = 76800;
    localparam int B1 = 1;
    localparam int H1 = 2;
    localparam int V1 = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    logic pclk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic vsync = 1'b1;
    logic href = 1'b0;
    logic [7:0] d = 8'h00;
    logic busy0, busy1, fd0, fd1, ov0, ov1;
    logic [A0:0] pc0;
    logic [A1:0] pc1;

    cam_capture_scaler_if #(.ADDR_W(A0), .PIX_W(8*B0)) bus0 ();
    cam_capture_scaler_if #(.ADDR_W(A1), .PIX_W(8*B1)) bus1 ();

    assign bus0.vsync = vsync;
    assign bus0.href  = href;
    assign bus0.d     = d;
    assign bus1.vsync = vsync;
    assign bus1.href  = href;
    assign bus1.d     = d;

    cam_capture_scaler #(
        .BPP(B0), .H_DEC(H0), .V_DEC(V0),
        .ADDR_W(A0), .DEPTH(D0), .CONTINUOUS(1)
    ) u0 (
        .pclk(pclk), .reset(reset), .bus(bus0), .start(start0),
        .busy(busy0), .frame_done(fd0), .overflow(ov0), .pix_count(pc0)
    );

    cam_capture_scaler #(
        .BPP(B1), .H_DEC(H1), .V_DEC(V1),
        .ADDR_W(A1), .DEPTH(D1), .CONTINUOUS(0)
    ) u1 (
        .pclk(pclk), .reset(reset), .bus(bus1), .start(start1),
        .busy(busy1), .frame_done(fd1), .overflow(ov1), .pix_count(pc1)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int w0 = 0, w1 = 0, fdc0 = 0, fdc1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int bpos = 0, line = 0, n0 = 0, n1 = 0;
    bit cap0 = 0, cap1 = 0;
    logic [31:0] hist = '0;

    always @(negedge pclk) begin
        if (!reset && bus0.we === 1'b1) begin
            w0++;
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL u0_write unexpected addr=%0d dout=%h", bus0.addr, bus0.dout);
            end else begin
                e0 = q0.pop_front();
                if (32'(bus0.addr) !== e0.addr || 32'(bus0.dout) !== e0.dout || cyc !== e0.cyc)
                begin
                    miscompares++;
                    $display("FAIL u0_write got addr=%0d dout=%h cyc=%0d want addr=%0d dout=%h cyc=%0d",
                             bus0.addr, bus0.dout, cyc, e0.addr, e0.dout, e0.cyc);
                end
            end
        end
        if (!reset && fd0 === 1'b1) begin
            fdc0++;
            vectors++;
            if (bus0.we !== 1'b0) begin
                miscompares++;
                $display("FAIL u0_done_with_write we=%b want 0", bus0.we);
            end
        end
    end

    always @(negedge pclk) begin
        if (!reset && bus1.we === 1'b1) begin
            w1++;
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL u1_write unexpected addr=%0d dout=%h", bus1.addr, bus1.dout);
            end else begin
                e1 = q1.pop_front();
                if (32'(bus1.addr) !== e1.addr || 32'(bus1.dout) !== e1.dout || cyc !== e1.cyc)
                begin
                    miscompares++;
                    $display("FAIL u1_write got addr=%0d dout=%h cyc=%0d want addr=%0d dout=%h cyc=%0d",
                             bus1.addr, bus1.dout, cyc, e1.addr, e1.dout, e1.cyc);
                end
            end
        end
        if (!reset && fd1 === 1'b1) begin
            fdc1++;
            vectors++;
            if (bus1.we !== 1'b0) begin
                miscompares++;
                $display("FAIL u1_done_with_write we=%b want 0", bus1.we);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input bit s0, input bit s1);
        @(negedge pclk);
        start0 = s0;
        start1 = s1;
        @(negedge pclk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic begin_frame(input bit c0, input bit c1);
        cap0 = c0;
        cap1 = c1;
        n0 = 0;
        n1 = 0;
        line = 0;
        bpos = 0;
        repeat (4) begin
            @(negedge pclk);
            vsync = 1'b1;
            href = 1'b0;
        end
        @(negedge pclk);
        vsync = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    // Byte sampled on the next edge; its pixel write must show 2 edges later
    task automatic drive_byte(input logic [7:0] v);
        @(negedge pclk);
        href = 1'b1;
        d = v;
        hist = {hist[23:0], v};
        if (cap0 && bpos % B0 == B0 - 1 && (bpos / B0) % H0 == 0 && line % V0 == 0) begin
            if (n0 < D0)
                q0.push_back('{addr: n0, dout: {16'h0, hist[15:0]}, cyc: cyc + 3});
            n0++;
        end
        if (cap1 && bpos % B1 == B1 - 1 && (bpos / B1) % H1 == 0 && line % V1 == 0) begin
            if (n1 < D1)
                q1.push_back('{addr: n1, dout: {24'h0, hist[7:0]}, cyc: cyc + 3});
            n1++;
        end
        bpos++;
    endtask

    task automatic end_line();
        repeat (4) begin
            @(negedge pclk);
            href = 1'b0;
        end
        bpos = 0;
        line++;
    endtask

    task automatic drive_lines(input int w, input int h, input int base);
        for (int l = 0; l < h; l++) begin
            for (int b = 0; b < w; b++)
                drive_byte(8'(base + l * w + b));
            end_line();
        end
    endtask

    task automatic end_frame();
        @(negedge pclk);
        vsync = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge pclk);
        reset = 1'b0;
        repeat (2) @(negedge pclk);
        vectors++;
        if (bus0.addr !== '0 || bus0.dout !== '0) begin
            miscompares++;
            $display("FAIL reset_u0_bus addr=%0d dout=%h want 0 0", bus0.addr, bus0.dout);
        end
        vectors++;
        if ({bus0.we, busy0, fd0, ov0} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_u0_flags we/busy/done/ovf=%b want 0000",
                     {bus0.we, busy0, fd0, ov0});
        end
        vectors++;
        if (pc0 !== '0) begin
            miscompares++;
            $display("FAIL reset_u0_pix_count got %0d want 0", pc0);
        end
        vectors++;
        if ({bus1.we, busy1, fd1, ov1} !== 4'b0 || pc1 !== '0 || bus1.addr !== '0) begin
            miscompares++;
            $display("FAIL reset_u1 flags=%b pix_count=%0d addr=%0d want 0",
                     {bus1.we, busy1, fd1, ov1}, pc1, bus1.addr);
        end
    endtask

    task automatic test_basic_frame();
        int f0, f1;
        f0 = fdc0;
        f1 = fdc1;
        pulse_start(1'b1, 1'b1);
        vectors++;
        if ({busy0, busy1} !== 2'b11) begin
            miscompares++;
            $display("FAIL basic_armed busy=%b want 11", {busy0, busy1});
        end
        begin_frame(1'b1, 1'b1);
        drive_lines(16, 4, 0);
        end_frame();
        vectors++;
        if (32'(pc0) !== 32 || 32'(pc1) !== 16) begin
            miscompares++;
            $display("FAIL basic_pix_count got %0d/%0d want 32/16", pc0, pc1);
        end
        vectors++;
        if (fdc0 - f0 !== 1 || fdc1 - f1 !== 1) begin
            miscompares++;
            $display("FAIL basic_frame_done got %0d/%0d want 1/1", fdc0 - f0, fdc1 - f1);
        end
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL basic_missing_writes pending %0d/%0d want 0", q0.size(), q1.size());
        end
        vectors++;
        if ({busy0, busy1} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_busy_after busy=%b want 10", {busy0, busy1});
        end
    endtask

    task automatic test_decimation();
        pulse_start(1'b0, 1'b1);
        begin_frame(1'b1, 1'b1);
        drive_lines(64, 30, 8'h11);
        end_frame();
        vectors++;
        if (32'(pc1) !== 320 || ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL decim_u1 pix_count=%0d ovf=%b want 320 0", pc1, ov1);
        end
        vectors++;
        if (32'(pc0) !== D0 || ov0 !== 1'b1) begin
            miscompares++;
            $display("FAIL decim_u0 pix_count=%0d ovf=%b want %0d 1", pc0, ov0, D0);
        end
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL decim_missing_writes pending %0d/%0d want 0", q0.size(), q1.size());
        end
    endtask

    task automatic test_overflow();
        int w;
        begin_frame(1'b1, 1'b0);
        vectors++;
        if (ov0 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_at_start got %b want 0", ov0);
        end
        w = w0;
        drive_lines(32, 16, 8'h40);
        end_frame();
        vectors++;
        if (ov0 !== 1'b1 || 32'(pc0) !== 100 || w0 - w !== 100) begin
            miscompares++;
            $display("FAIL ovf_frame ovf=%b pix_count=%0d writes=%0d want 1 100 100",
                     ov0, pc0, w0 - w);
        end
        begin_frame(1'b1, 1'b0);
        vectors++;
        if (ov0 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_next got %b want 0", ov0);
        end
        drive_lines(16, 2, 8'h80);
        end_frame();
        vectors++;
        if (32'(pc0) !== 16 || ov0 !== 1'b0 || q0.size() != 0) begin
            miscompares++;
            $display("FAIL ovf_after pix_count=%0d ovf=%b pending=%0d want 16 0 0",
                     pc0, ov0, q0.size());
        end
    endtask

    task automatic test_single_shot();
        int f1, w;
        f1 = fdc1;
        w = w1;
        pulse_start(1'b0, 1'b1);
        begin_frame(1'b1, 1'b1);
        pulse_start(1'b0, 1'b1);
        drive_lines(16, 6, 8'h20);
        end_frame();
        for (int k = 0; k < 2; k++) begin
            begin_frame(1'b1, 1'b0);
            drive_lines(16, 6, 8'h90 + k);
            end_frame();
        end
        vectors++;
        if (fdc1 - f1 !== 1 || w1 - w !== 16 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_shot done=%0d writes=%0d busy=%b want 1 16 0",
                     fdc1 - f1, w1 - w, busy1);
        end
        pulse_start(1'b0, 1'b1);
        begin_frame(1'b1, 1'b1);
        drive_lines(16, 6, 8'h50);
        end_frame();
        vectors++;
        if (fdc1 - f1 !== 2 || w1 - w !== 32 || busy1 !== 1'b0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL single_shot_rearm done=%0d writes=%0d busy=%b pending=%0d want 2 32 0 0",
                     fdc1 - f1, w1 - w, busy1, q1.size());
        end
    endtask

    task automatic test_reset_mid();
        int w, f;
        bit hit;
        w = w0;
        hit = 1'b0;
        begin_frame(1'b1, 1'b0);
        for (int l = 0; l < 4 && !hit; l++) begin
            for (int b = 0; b < 16 && !hit; b++) begin
                drive_byte(8'(l * 16 + b));
                if (w0 - w >= 10)
                    hit = 1'b1;
            end
            if (!hit)
                end_line();
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reset_mid_no_writes got %0d want 10", w0 - w);
        end
        @(posedge pclk);
        #1;
        reset = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        vectors++;
        if (bus0.we !== 1'b0 || bus0.addr !== '0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid we=%b addr=%0d busy=%b want 0 0 0",
                     bus0.we, bus0.addr, busy0);
        end
        @(negedge pclk);
        href = 1'b0;
        repeat (2) @(negedge pclk);
        reset = 1'b0;
        end_frame();
        w = w0;
        f = fdc0;
        begin_frame(1'b0, 1'b0);
        drive_lines(16, 4, 8'hC0);
        end_frame();
        vectors++;
        if (w0 - w !== 0 || fdc0 - f !== 0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_idle writes=%0d done=%0d busy=%b want 0 0 0",
                     w0 - w, fdc0 - f, busy0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_decimation();
        test_overflow();
        test_single_shot();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
